// File: rtl/pkt_echo_pkg.sv
// Shared types and sizing helpers for the packet echo buffer.
package pkt_echo_pkg;

   // Echo buffer control states
   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_SEND  = 2'd1,
      S_WAIT  = 2'd2,
      S_CLEAR = 2'd3
   } state_t;

   // Buffer address width for a given depth
   function automatic int ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   localparam int DEPTH_DEF = 16;
   localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);

endpackage

// File: rtl/pkt_echo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
module pkt_echo_ram #(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   // Write port and registered read port; contents are never reset
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/pkt_echo_buf.sv
// Packet echo buffer: collects PKT_LEN received words, then replays them to
// the transmitter one word per i_tx_done handshake.
// Optional feature macro: PKT_ECHO_TIMEOUT_EN (flush a partial packet after
// TIMEOUT_CYC idle clocks).
module pkt_echo_buf
   import pkt_echo_pkg::*;
#(
   parameter int DW          = 8,
   parameter int DEPTH       = 16,
   parameter int PKT_LEN     = 10,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_rx_dv,
   input  logic [DW-1:0] i_rx_byte,
   output logic          o_tx_dv,
   output logic [DW-1:0] o_tx_byte,
   input  logic          i_tx_done,
   output logic          o_busy,
   output logic          o_led,
   output logic [7:0]    o_drop_cnt,
   output logic [15:0]   o_pkt_cnt
);

   localparam int AW = ptr_w(DEPTH);
   // Pointers carry one extra bit so a fill level of exactly DEPTH is representable
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LEN_C = CW'(PKT_LEN);

   if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 || DEPTH > 1024 ||
       PKT_LEN < 1 || PKT_LEN > DEPTH || TIMEOUT_CYC < 1) begin : g_param_err
      $error("pkt_echo_buf: illegal parameter set");
   end

   state_t        r_state;
   logic [CW-1:0] r_wr_ptr;
   logic [CW-1:0] r_rd_ptr;
   logic [CW-1:0] r_fill;
   logic          r_send_ph;   // 0: read address presented, 1: RAM data valid
   logic          w_we;
   logic [DW-1:0] w_ram_q;

`ifdef PKT_ECHO_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
   logic [31:0] r_tmo;
`endif

   assign w_we   = (r_state == S_FILL) && i_rx_dv;
   assign o_busy = (r_state != S_FILL);

   pkt_echo_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (i_rx_byte),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (w_ram_q)
   );

   // Control FSM with registered strobe, data and counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_FILL;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fill     <= '0;
         r_send_ph  <= 1'b0;
         o_tx_dv    <= 1'b0;
         o_tx_byte  <= '0;
         o_led      <= 1'b0;
         o_drop_cnt <= '0;
         o_pkt_cnt  <= '0;
`ifdef PKT_ECHO_TIMEOUT_EN
         r_tmo      <= '0;
`endif
      end else begin
         o_tx_dv <= 1'b0;
         if (i_rx_dv && r_state != S_FILL && o_drop_cnt != 8'hFF)
            o_drop_cnt <= o_drop_cnt + 8'd1;
         case (r_state)
            S_FILL: begin
               if (i_rx_dv) begin
                  r_wr_ptr <= r_wr_ptr + CW'(1);
                  o_led    <= ~o_led;
                  if (r_wr_ptr + CW'(1) == LEN_C) begin
                     r_state   <= S_SEND;
                     r_fill    <= LEN_C;
                     r_send_ph <= 1'b0;
                  end
               end
`ifdef PKT_ECHO_TIMEOUT_EN
               if (i_rx_dv) begin
                  r_tmo <= '0;
               end else if (r_wr_ptr != '0) begin
                  if (r_tmo == TMO_LAST) begin
                     r_tmo     <= '0;
                     r_state   <= S_SEND;
                     r_fill    <= r_wr_ptr;
                     r_send_ph <= 1'b0;
                  end else begin
                     r_tmo <= r_tmo + 32'd1;
                  end
               end
`endif
            end
            S_SEND: begin
               // Wait one cycle for the registered RAM read, then strobe
               if (!r_send_ph) begin
                  r_send_ph <= 1'b1;
               end else begin
                  r_send_ph <= 1'b0;
                  o_tx_dv   <= 1'b1;
                  o_tx_byte <= w_ram_q;
                  r_rd_ptr  <= r_rd_ptr + CW'(1);
                  r_state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_tx_done)
                  r_state <= (r_rd_ptr != r_fill) ? S_SEND : S_CLEAR;
            end
            S_CLEAR: begin
               r_wr_ptr  <= '0;
               r_rd_ptr  <= '0;
               o_pkt_cnt <= o_pkt_cnt + 16'd1;
               r_state   <= S_FILL;
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_echo_buf.sv
// Directed bench for pkt_echo_buf: fill/echo, pacing, drops, reset, timeout.
module tb_pkt_echo_buf;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_rx_dv = 1'b0;
   logic [7:0]  i_rx_byte = 8'h00;
   logic        i_tx_done = 1'b0;
   logic        o_tx_dv;
   logic [7:0]  o_tx_byte;
   logic        o_busy;
   logic        o_led;
   logic [7:0]  o_drop_cnt;
   logic [15:0] o_pkt_cnt;

   int checks = 0;
   int failures = 0;
   int stab_err = 0;
   logic [7:0] q_tx [$];
   logic       pend = 1'b0;
   logic [7:0] hold = 8'h00;

   always #5 clk = ~clk;

   pkt_echo_buf #(.DW(8), .DEPTH(16), .PKT_LEN(10), .TIMEOUT_CYC(100)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_rx_dv    (i_rx_dv),
      .i_rx_byte  (i_rx_byte),
      .o_tx_dv    (o_tx_dv),
      .o_tx_byte  (o_tx_byte),
      .i_tx_done  (i_tx_done),
      .o_busy     (o_busy),
      .o_led      (o_led),
      .o_drop_cnt (o_drop_cnt),
      .o_pkt_cnt  (o_pkt_cnt)
   );

   // Record every transmit strobe and watch o_tx_byte hold between strobes
   always @(negedge clk) begin
      if (!reset) begin
         pend = 1'b0;
      end else if (o_tx_dv === 1'b1) begin
         q_tx.push_back(o_tx_byte);
         hold = o_tx_byte;
         pend = 1'b1;
      end else if (pend && o_tx_byte !== hold) begin
         stab_err++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_pkt(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         i_rx_dv   = 1'b1;
         i_rx_byte = base + 8'(i);
         @(negedge clk);
      end
      i_rx_dv = 1'b0;
   endtask

   task automatic wait_dv(output int cyc);
      cyc = 0;
      while (o_tx_dv !== 1'b1 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Answer n strobes, each i_tx_done dly cycles after the strobe,
   // injecting up to inj received words while waiting
   task automatic drain(input int n, input int dly, input int inj, output int lat0);
      int left;
      int c;
      left = inj;
      lat0 = -1;
      for (int i = 0; i < n; i++) begin
         wait_dv(c);
         if (i == 0) lat0 = c;
         chk("dv_seen", {31'd0, o_tx_dv}, 32'd1);
         if (o_tx_dv !== 1'b1) return;
         for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            if (left > 0) begin
               i_rx_dv   = 1'b1;
               i_rx_byte = 8'hEE;
               left--;
            end else begin
               i_rx_dv = 1'b0;
            end
         end
         i_tx_done = 1'b1;
         @(negedge clk);
         i_tx_done = 1'b0;
         i_rx_dv   = 1'b0;
      end
   endtask

   task automatic chk_bytes(input string tag, input logic [7:0] base, input int n);
      logic [7:0] v;
      chk({tag, "_count"}, q_tx.size(), n);
      for (int i = 0; i < n; i++) begin
         v = (i < q_tx.size()) ? q_tx[i] : 8'hxx;
         chk(tag, {24'd0, v}, {24'd0, base + 8'(i)});
      end
   endtask

   initial begin
      int lat;
      int c;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tx_dv",   {31'd0, o_tx_dv},   32'd0);
      chk("rst_tx_byte", {24'd0, o_tx_byte}, 32'd0);
      chk("rst_led",     {31'd0, o_led},     32'd0);
      chk("rst_drop",    {24'd0, o_drop_cnt}, 32'd0);
      chk("rst_pkt",     {16'd0, o_pkt_cnt}, 32'd0);
      chk("rst_busy",    {31'd0, o_busy},    32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Fill/echo 0x30..0x39, first strobe 2 cycles after entering S_SEND
      q_tx.delete();
      send_pkt(8'h30, 10);
      chk("busy_after_fill", {31'd0, o_busy}, 32'd1);
      drain(10, 3, 0, lat);
      chk("first_dv_latency", lat, 2);
      repeat (4) @(negedge clk);
      chk_bytes("echo1", 8'h30, 10);
      chk("echo1_pkt", {16'd0, o_pkt_cnt}, 32'd1);
      chk("echo1_led", {31'd0, o_led}, 32'd0);
      chk("echo1_busy", {31'd0, o_busy}, 32'd0);

      // Transmit pacing: done 50 cycles after each strobe
      q_tx.delete();
      stab_err = 0;
      send_pkt(8'h40, 10);
      drain(10, 50, 0, lat);
      repeat (4) @(negedge clk);
      chk_bytes("pace", 8'h40, 10);
      chk("pace_stable", stab_err, 0);
      chk("pace_pkt", {16'd0, o_pkt_cnt}, 32'd2);

      // Three words dropped during drain
      q_tx.delete();
      send_pkt(8'h50, 10);
      drain(10, 3, 3, lat);
      repeat (4) @(negedge clk);
      chk("drop3", {24'd0, o_drop_cnt}, 32'd3);
      chk_bytes("drop_echo", 8'h50, 10);
      chk("drop_pkt", {16'd0, o_pkt_cnt}, 32'd3);

      // 300 more drops saturate at 255
      q_tx.delete();
      send_pkt(8'hA0, 10);
      drain(10, 50, 300, lat);
      repeat (4) @(negedge clk);
      chk("drop_sat", {24'd0, o_drop_cnt}, 32'd255);
      chk_bytes("sat_echo", 8'hA0, 10);

      // Reset after the 4th strobe aborts the packet
      q_tx.delete();
      send_pkt(8'h60, 10);
      drain(3, 5, 0, lat);
      wait_dv(c);
      chk("dv4_seen", {31'd0, o_tx_dv}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (30) @(negedge clk);
      chk("rstmid_no_dv", q_tx.size(), 4);
      chk("rstmid_pkt", {16'd0, o_pkt_cnt}, 32'd0);
      chk("rstmid_drop", {24'd0, o_drop_cnt}, 32'd0);
      chk("rstmid_busy", {31'd0, o_busy}, 32'd0);
      q_tx.delete();
      send_pkt(8'h70, 10);
      drain(10, 2, 0, lat);
      repeat (4) @(negedge clk);
      chk_bytes("post_rst", 8'h70, 10);
      chk("post_rst_pkt", {16'd0, o_pkt_cnt}, 32'd1);

      // Partial packet of 4 words then idle
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      q_tx.delete();
      send_pkt(8'h80, 4);
`ifdef PKT_ECHO_TIMEOUT_EN
      drain(4, 2, 0, lat);
      repeat (4) @(negedge clk);
      chk_bytes("tmo", 8'h80, 4);
      chk("tmo_pkt", {16'd0, o_pkt_cnt}, 32'd1);
`else
      repeat (300) @(negedge clk);
      chk("notmo_no_dv", q_tx.size(), 0);
      chk("notmo_busy", {31'd0, o_busy}, 32'd0);
      chk("notmo_pkt", {16'd0, o_pkt_cnt}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
